// File: rtl/board_ctrl.sv
// board_ctrl -- 10x10 game-board cell storage shared by the VGA display read
// path and a game-logic command engine.
//
// The storage has a single access slot per clock. The display owns it whenever
// an active pixel falls inside the board window. In every other cycle the slot
// is free, and the command engine uses it to read, write, collapse a row or
// clear the board.
//
// Optional feature: define BOARD_ROW_FULL_EN to build the registered per-row
// "all cells nonzero" detector. When it is undefined, row_full is tied to 0.
//
// Ports
//   clk, rst_n              pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt, valid     pixel position and active-video qualifier
//   disp_cell               cell value under the previous cycle's pixel
//   disp_in_board           previous pixel was active and inside the window
//   cmd_valid/cmd_ready     command handshake (ready = engine idle)
//   cmd_op                  00 read, 01 write, 10 collapse row, 11 clear all
//   cmd_x, cmd_y, cmd_wdata column, row (0 = top), write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata, rsp_err      read result, out-of-range flag (with rsp_valid)
//   row_full                per-row full flags
module board_ctrl #(
    parameter int COLS    = 10,
    parameter int ROWS    = 10,
    parameter int CELL_W  = 3,
    parameter int X0      = 120,
    parameter int Y0      = 40,
    parameter int CELL_PX = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic              valid,
    output logic [CELL_W-1:0] disp_cell,
    output logic              disp_in_board,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_x,
    input  logic [3:0]        cmd_y,
    input  logic [CELL_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [CELL_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ROWS-1:0]   row_full
);

    localparam int         N     = ROWS * COLS;
    localparam int         AW    = $clog2(N);
    localparam logic [9:0] XL    = 10'(X0);
    localparam logic [9:0] XH    = 10'(X0 + COLS * CELL_PX);
    localparam logic [9:0] YL    = 10'(Y0);
    localparam logic [9:0] YH    = 10'(Y0 + ROWS * CELL_PX);
    localparam logic [9:0] PX    = 10'(CELL_PX);
    localparam logic [3:0] COLS4 = 4'(COLS);
    localparam logic [3:0] ROWS4 = 4'(ROWS);
    localparam logic [3:0] CMAX  = 4'(COLS - 1);
    localparam logic [3:0] RMAX  = 4'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_COLLAPSE, S_CLEAR, S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        r_q, r_d, c_q, c_d;
    logic [CELL_W-1:0] wdata_q, wdata_d;
    logic [CELL_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              live_q;
    logic [CELL_W-1:0] mem_q [N];
    logic [CELL_W-1:0] disp_cell_q;
    logic              disp_in_board_q;

    logic              in_win;
    logic [9:0]        dh, dv;
    logic [3:0]        cx, cy;
    logic [AW-1:0]     daddr, eaddr, src;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [CELL_W-1:0] wval;

    // Display coordinate decode; offsets are forced to 0 outside the window
    // so the divider never produces an out-of-range address.
    always_comb begin
        in_win = valid && (h_cnt >= XL) && (h_cnt < XH) &&
                 (v_cnt >= YL) && (v_cnt < YH);
        dh     = in_win ? (h_cnt - XL) : '0;
        dv     = in_win ? (v_cnt - YL) : '0;
        cx     = 4'(dh / PX);
        cy     = 4'(dv / PX);
        daddr  = AW'(cy * COLS + cx);
    end

    // Engine address from the row/column counters. For a collapse move, the
    // source is the same column one row up. That address is only used when
    // r_q != 0.
    assign eaddr = AW'(r_q * COLS + c_q);
    assign src   = eaddr - AW'(COLS);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we      = 1'b0;
        waddr   = eaddr;
        wval    = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    r_d     = cmd_y;
                    c_d     = cmd_x;
                    if (cmd_op == 2'b11) begin
                        r_d     = '0;
                        c_d     = '0;
                        state_d = S_CLEAR;
                    end else if ((cmd_x >= COLS4) || (cmd_y >= ROWS4)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        case (cmd_op)
                            2'b00:   state_d = S_READ;
                            2'b01:   state_d = S_WRITE;
                            default: begin
                                c_d     = '0;
                                state_d = S_COLLAPSE;
                            end
                        endcase
                    end
                end
            end
            S_READ: if (!in_win) begin
                rdata_d = mem_q[eaddr];
                state_d = S_RESP;
            end
            S_WRITE: if (!in_win) begin
                we      = 1'b1;
                wval    = wdata_q;
                state_d = S_RESP;
            end
            // Walk upward from the target row, copying each row down. The
            // final pass (row 0) fills with zeros.
            S_COLLAPSE: if (!in_win) begin
                we   = 1'b1;
                wval = (r_q == '0) ? '0 : mem_q[src];
                if (c_q == CMAX) begin
                    c_d = '0;
                    if (r_q == '0) state_d = S_RESP;
                    else           r_d = r_q - 4'd1;
                end else begin
                    c_d = c_q + 4'd1;
                end
            end
            S_CLEAR: if (!in_win) begin
                we = 1'b1;
                if (c_q == CMAX) begin
                    c_d = '0;
                    if (r_q == RMAX) state_d = S_RESP;
                    else             r_d = r_q + 4'd1;
                end else begin
                    c_d = c_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wval;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_cell_q     <= '0;
            disp_in_board_q <= 1'b0;
        end else begin
            disp_cell_q     <= in_win ? mem_q[daddr] : '0;
            disp_in_board_q <= in_win;
        end
    end

    // live_q keeps the engine from accepting commands while reset is held
    // and during the first clock after release.
    assign cmd_ready     = live_q && (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign disp_cell     = disp_cell_q;
    assign disp_in_board = disp_in_board_q;

`ifdef BOARD_ROW_FULL_EN
    logic [ROWS-1:0] row_full_q, row_full_d;

    // Evaluate the rows as they will be after this cycle's write, so a flag
    // changes together with the storage it describes.
    always_comb begin
        row_full_d = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (we && (waddr == AW'(r * COLS + c))) begin
                    if (wval == '0) row_full_d[r] = 1'b0;
                end else if (mem_q[r * COLS + c] == '0) begin
                    row_full_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) row_full_q <= '0;
        else        row_full_q <= row_full_d;
    end

    assign row_full = row_full_q;
`else
    assign row_full = '0;
`endif

endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl: reset state, read/write, display path and
// window edges, display stalls, collapse, error handling, clear, and abort.
module tb_board_ctrl;
    localparam int BOUND = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt, v_cnt;
    logic       valid;
    logic [2:0] disp_cell;
    logic       disp_in_board;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_x, cmd_y;
    logic [2:0] cmd_wdata;
    logic       rsp_valid;
    logic [2:0] rsp_rdata;
    logic       rsp_err;
    logic [9:0] row_full;

    int nvec = 0;
    int nerr = 0;

    board_ctrl dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .disp_cell(disp_cell), .disp_in_board(disp_in_board),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .row_full(row_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic v);
        h_cnt = 10'(120 + x * 40 + 7);
        v_cnt = 10'(40 + y * 40 + 13);
        valid = v;
    endtask

    // Issue one command from IDLE and wait for its response. lat counts
    // cycles from the accepting edge to the edge that raises rsp_valid.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                          input logic [2:0] wd, output int lat,
                          output logic [2:0] rd, output logic er);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < BOUND) begin
            step();
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        step();
    endtask

    initial begin
        int         lat;
        int         bad;
        logic [2:0] rd;
        logic       er;

        rst_n = 1'b0; valid = 1'b0; h_cnt = '0; v_cnt = '0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_wdata = '0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_disp_cell", disp_cell, 0);
        chk("rst_disp_in_board", disp_in_board, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_row_full", row_full, 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_release", cmd_ready, 1);

        // Basic write then read.
        do_cmd(2'b01, 4'd3, 4'd4, 3'd5, lat, rd, er);
        chk("wr_lat", lat, 2);
        chk("wr_err", er, 0);
        do_cmd(2'b00, 4'd3, 4'd4, 3'd0, lat, rd, er);
        chk("rd_lat", lat, 2);
        chk("rd_data", rd, 5);
        chk("rd_err", er, 0);
        do_cmd(2'b01, 4'd9, 4'd9, 3'd6, lat, rd, er);
        chk("wr99_rdata_zero", rd, 0);

        // Display path, one-cycle latency, window edges.
        pix(3, 4, 1'b1); step();
        chk("disp_34_cell", disp_cell, 5);
        chk("disp_34_in", disp_in_board, 1);
        h_cnt = 10'd119; step();
        chk("disp_h119_cell", disp_cell, 0);
        chk("disp_h119_in", disp_in_board, 0);
        pix(3, 4, 1'b0); step();
        chk("disp_novalid_in", disp_in_board, 0);
        h_cnt = 10'd519; v_cnt = 10'd439; valid = 1'b1; step();
        chk("disp_corner_cell", disp_cell, 6);
        chk("disp_corner_in", disp_in_board, 1);
        h_cnt = 10'd520; step();
        chk("disp_h520_in", disp_in_board, 0);
        h_cnt = 10'd519; v_cnt = 10'd440; step();
        chk("disp_v440_in", disp_in_board, 0);

        // Write stalled by display ownership of the slot.
        pix(3, 4, 1'b1);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_x = 4'd3; cmd_y = 4'd4; cmd_wdata = 3'd2;
        step();
        cmd_valid = 1'b0;
        chk("stall_ready_low", cmd_ready, 0);
        step();
        chk("stall_rsp1", rsp_valid, 0);
        chk("stall_old_cell", disp_cell, 5);
        step();
        chk("stall_rsp2", rsp_valid, 0);
        chk("stall_old_cell2", disp_cell, 5);
        valid = 1'b0; step();
        chk("stall_rsp_now", rsp_valid, 1);
        chk("stall_ready_resp", cmd_ready, 0);
        valid = 1'b1; step();
        chk("stall_new_cell", disp_cell, 2);
        chk("stall_ready_back", cmd_ready, 1);
        valid = 1'b0;

        // Fill rows 9 and 8, then collapse row 9.
        for (int c = 0; c < 10; c++) begin
            do_cmd(2'b01, 4'(c), 4'd9, 3'd1, lat, rd, er);
            do_cmd(2'b01, 4'(c), 4'd8, 3'd2, lat, rd, er);
        end
`ifdef BOARD_ROW_FULL_EN
        chk("row_full_pre", row_full, 10'h300);
`else
        chk("row_full_pre", row_full, 0);
`endif
        do_cmd(2'b10, 4'd0, 4'd9, 3'd0, lat, rd, er);
        chk("coll9_lat", lat, 101);
        chk("coll9_err", er, 0);
        do_cmd(2'b00, 4'd0, 4'd9, 3'd0, lat, rd, er);
        chk("coll9_r9c0", rd, 2);
        do_cmd(2'b00, 4'd9, 4'd9, 3'd0, lat, rd, er);
        chk("coll9_r9c9", rd, 2);
        do_cmd(2'b00, 4'd4, 4'd8, 3'd0, lat, rd, er);
        chk("coll9_r8", rd, 0);
        do_cmd(2'b00, 4'd3, 4'd5, 3'd0, lat, rd, er);
        chk("coll9_moved", rd, 2);
        do_cmd(2'b00, 4'd3, 4'd4, 3'd0, lat, rd, er);
        chk("coll9_vacated", rd, 0);
`ifdef BOARD_ROW_FULL_EN
        chk("row_full_post", row_full, 10'h200);
`else
        chk("row_full_post", row_full, 0);
`endif

        // Collapse of row 0 clears only row 0.
        do_cmd(2'b01, 4'd5, 4'd0, 3'd4, lat, rd, er);
        do_cmd(2'b10, 4'd0, 4'd0, 3'd0, lat, rd, er);
        chk("coll0_lat", lat, 11);
        do_cmd(2'b00, 4'd5, 4'd0, 3'd0, lat, rd, er);
        chk("coll0_cleared", rd, 0);
        do_cmd(2'b00, 4'd3, 4'd5, 3'd0, lat, rd, er);
        chk("coll0_keep", rd, 2);

        // Out-of-range coordinates.
        do_cmd(2'b01, 4'd10, 4'd4, 3'd7, lat, rd, er);
        chk("oor_wr_err", er, 1);
        chk("oor_wr_done", lat < BOUND, 1);
        do_cmd(2'b00, 4'd0, 4'd5, 3'd0, lat, rd, er);
        chk("oor_no_alias", rd, 0);
        chk("oor_ok_err", er, 0);
        do_cmd(2'b00, 4'd2, 4'd12, 3'd0, lat, rd, er);
        chk("oor_rd_err", er, 1);
        chk("oor_rd_data", rd, 0);

        // Full clear.
        do_cmd(2'b11, 4'd0, 4'd0, 3'd0, lat, rd, er);
        chk("clr_lat", lat, 101);
        do_cmd(2'b00, 4'd9, 4'd9, 3'd0, lat, rd, er);
        chk("clr_r9", rd, 0);
        chk("clr_row_full", row_full, 0);

        // Clear aborted by reset at cycle 40: no response is issued.
        do_cmd(2'b01, 4'd5, 4'd9, 3'd3, lat, rd, er);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_x = '0; cmd_y = '0;
        step();
        cmd_valid = 1'b0;
        bad = 0;
        for (int i = 1; i < 40; i++) begin
            if (rsp_valid !== 1'b0) bad++;
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("abort_ready_low", cmd_ready, 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (rsp_valid !== 1'b0) bad++;
        end
        chk("abort_no_rsp", bad, 0);
        bad = 0;
        for (int y = 0; y < 10; y++) begin
            for (int x = 0; x < 10; x++) begin
                pix(x, y, 1'b1);
                step();
                if (disp_cell !== 3'd0 || disp_in_board !== 1'b1) bad++;
            end
        end
        valid = 1'b0;
        chk("abort_all_zero", bad, 0);
        step();
        do_cmd(2'b00, 4'd5, 4'd9, 3'd0, lat, rd, er);
        chk("abort_idle_lat", lat, 2);
        chk("abort_cell59", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/board_ctrl.md
# board_ctrl

Owner of the 10x10 game-board cell storage feeding the VGA pixel generator. Serves a display read on every pixel clock inside the board window with fixed one-cycle latency. Shares the single storage access slot with a game-logic command port (read, write, row collapse, clear) through a valid/ready handshake. The display always wins the slot. Sits between the game FSM and the pixel generator, in the VGA clock domain.

## Interface
- `COLS`, 10: board columns.
- `ROWS`, 10: board rows.
- `CELL_W`, 3: bits per cell; 0 = empty, nonzero = colour index.
- `X0`, 120: first h_cnt of the board window.
- `Y0`, 40: first v_cnt of the board window.
- `CELL_PX`, 40: pixel size of one cell (square).
- `clk` in 1: pixel clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `h_cnt` in 10: horizontal pixel counter.
- `v_cnt` in 10: vertical pixel counter.
- `valid` in 1: active-video qualifier.
- `disp_cell` out CELL_W: cell value under the pixel presented one cycle earlier.
- `disp_in_board` out 1: the pixel presented one cycle earlier was valid and inside the window.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: controller idle; a command is accepted when cmd_valid && cmd_ready.
- `cmd_op` in 2: 00 read, 01 write, 10 collapse row, 11 clear all.
- `cmd_x` in 4: column.
- `cmd_y` in 4: row (0 = top).
- `cmd_wdata` in CELL_W: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out CELL_W: read result; 0 for non-read ops.
- `rsp_err` out 1: coordinate out of range (valid with rsp_valid).
- `row_full` out ROWS: per-row all-cells-nonzero flags (see Configuration).

## Operation
- Window: X0 <= h_cnt < X0+COLS*CELL_PX and Y0 <= v_cnt < Y0+ROWS*CELL_PX.
- Display coordinates: cx = (h_cnt-X0)/CELL_PX, cy = (v_cnt-Y0)/CELL_PX.
  - Use 10-bit unsigned arithmetic, evaluated only inside the window.
  - Either division or compare chains are acceptable.
- Slot arbitration: the display owns the slot whenever valid && in window. Otherwise the slot is "free" and goes to the command engine.
- FSM states: IDLE, READ, WRITE, COLLAPSE, CLEAR, RESP.
  - IDLE: cmd_ready=1. On acceptance, latch op/x/y/wdata and go to the op state.
  - Out-of-range x/y on read, write or collapse: go to RESP with rsp_err=1 and no storage change.
  - READ / WRITE: on the first free slot, read into the rsp register or write the cell; then go to RESP.
  - COLLAPSE y: one cell move per free slot.
    - Order: r=y down to 1, c=0..COLS-1: cell[r][c] <= cell[r-1][c].
    - Then row 0, c=0..COLS-1: cell[0][c] <= 0.
    - Takes (y+1)*COLS free slots; then go to RESP.
    - Collapse of row 0 only clears row 0.
  - CLEAR: one cell zeroed per free slot, row-major, ROWS*COLS slots; then go to RESP.
  - RESP: rsp_valid=1 for one cycle; go to IDLE.
- The engine's internal c/r counters advance only on free slots and wrap c at COLS-1.
- Display reads observe storage mid-collapse or mid-clear; partially updated frames are acceptable.

## Timing
- Reset values: disp_cell=0, disp_in_board=0, cmd_ready=0 while rst_n low and 1 from the first clock after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, row_full=0. All cells 0. FSM in IDLE.
- Reset asserted mid-operation aborts the operation; no rsp_valid is issued.
- Display latency is exactly 1 cycle. Outside the window or with valid=0: disp_cell=0, disp_in_board=0.
- Command latency, acceptance to rsp_valid, with all slots free:
  - READ and WRITE: 2 cycles.
  - COLLAPSE: (y+1)*COLS+1 cycles.
  - CLEAR: ROWS*COLS+1 cycles.
  - Each display-owned cycle stalls the engine by one cycle.
- cmd_ready is low from the acceptance cycle through the RESP cycle, and high again in the cycle after RESP.
- A write and a display read of the same cell in the same cycle cannot occur (single slot). A write lands before any later display read.

## Configuration
- `BOARD_ROW_FULL_EN` defined:
  - row_full[r] is registered and updated on the cycle after any write to row r or any collapse/clear move into row r.
  - It is 1 iff all COLS cells of row r are nonzero.
- Undefined: row_full is tied to 0 and no detection logic is built.

## Test plan
- Reset, then write (3,4)=5 with valid=0 → rsp_valid 2 cycles after acceptance. Read (3,4) → rsp_rdata=5, rsp_err=0.
- Present h_cnt=120+3*40+7, v_cnt=40+4*40, valid=1 → next cycle disp_cell=5, disp_in_board=1. h_cnt=119 → disp_cell=0, disp_in_board=0.
- Write during active video inside the window → rsp_valid delayed until the first cycle with valid=0 or the pixel outside the window. Storage is unchanged before that cycle.
- Fill row 9 with 1s and row 8 with 2s, then collapse y=9 with valid=0 → rsp after 101 cycles. Row 9 = all 2s, row 0 = all 0s. With BOARD_ROW_FULL_EN, row_full[9]=1 before and after the collapse.
- Write x=10 → rsp_err=1, storage unchanged. Issue clear all, pull rst_n low at cycle 40 → all cells 0, rsp_valid never pulses.
